uart_rx_fifo: RTL

//  Receive buffer between the UART bit-level receiver and the CPU register interface.

---
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// ============================================================================
//  Module   : uart_rx_fifo
//  Brief    : UART receive buffer: edge-captured bytes into a FWFT FIFO with
//             level, full, sticky overrun/break and threshold interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_break,
  input  logic                  rd,
  input  logic                  err_clr,
  input  logic [DEPTH_LOG2:0]   thresh,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overrun,
  output logic                  break_flag,
  output logic                  thresh_irq
);

  localparam int                  c_depth_int = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_depth     = (DEPTH_LOG2+1)'(c_depth_int);
  localparam logic [DEPTH_LOG2:0] c_lvl_one   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     r_mem [c_depth_int];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_in_valid_q;
  logic                  r_in_break_q;
  logic                  r_overrun;
  logic                  r_break_flag;
  logic                  r_thresh_irq;

  logic                  w_flush;
  logic                  w_push_req;
  logic                  w_brk_req;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_overrun_set;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  assign w_flush    = reset | clr;
  assign w_push_req = in_valid & ~r_in_valid_q;
  assign w_brk_req  = in_break & ~r_in_break_q;
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == c_depth);
  assign w_pop      = rd & ~w_empty;

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign w_push        = w_push_req & (~w_full | w_pop);
  assign w_overrun_set = w_push_req & w_full & ~w_pop;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + c_lvl_one;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - c_lvl_one;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_in_valid_q <= 1'b0;
      r_in_break_q <= 1'b0;
      r_overrun    <= 1'b0;
      r_break_flag <= 1'b0;
      r_thresh_irq <= 1'b0;
    end else begin
      r_in_valid_q <= in_valid;
      r_in_break_q <= in_break;
      r_level      <= w_level_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      // Sticky flags: a set event beats a simultaneous clear.
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_brk_req) begin
        r_break_flag <= 1'b1;
      end else if (err_clr) begin
        r_break_flag <= 1'b0;
      end
      r_thresh_irq <= (thresh != '0) && (w_level_nxt >= thresh);
    end
  end

  // Storage carries no reset; entries are only observable once written.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign out_valid  = ~w_empty;
  assign out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign full       = w_full;
  assign level      = r_level;
  assign overrun    = r_overrun;
  assign break_flag = r_break_flag;
  assign thresh_irq = r_thresh_irq;

endmodule

`default_nettype wire
